alu_result_buffer: RTL and testbench
====================================

Name: alu_result_buffer

Overview:
- Execute-to-writeback stage directly downstream of the 16-bit ALU.
- Captures each ALU result (ALU_OUT, FLAG_OUT {S,Z,C,V}) with its destination tag into a small in-order FIFO and presents it to writeback over a valid/ready handshake.
- Maintains the architectural flag register, updated per opcode class at accept time.
- Exposes the newest buffered entry for upstream forwarding/hazard checks.

Parameters:
DATA_W  16  result width, matches ALU datapath
DEST_W  3  destination register tag width
DEPTH  2  FIFO entries; power of two, >= 2

Ports:
CLK  in  1  clock, rising edge
N_RST  in  1  asynchronous active-low reset
FLUSH  in  1  synchronous flush of buffered entries
IN_VALID  in  1  upstream has a result this cycle
IN_READY  out  1  buffer can accept
ALU_OUT  in  DATA_W  ALU result
FLAG_OUT  in  4  ALU flags {S,Z,C,V}
S_ALU  in  4  opcode that produced the result
IN_DEST  in  DEST_W  destination register
IN_WB_EN  in  1  result is to be written back
IN_FLAG_WE  in  1  instruction may update flags
OUT_VALID  out  1  head entry valid
OUT_READY  in  1  writeback accepts head
OUT_DATA  out  DATA_W  head result
OUT_DEST  out  DEST_W  head destination
OUT_WB_EN  out  1  head write enable
FLAGS  out  4  architectural flags {S,Z,C,V}
FWD_VALID  out  1  newest entry valid and has WB_EN=1
FWD_DEST  out  DEST_W  newest entry destination
FWD_DATA  out  DATA_W  newest entry data
COUNT  out  clog2(DEPTH)+1  occupancy

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low (N_RST). On assertion:
  - all entries invalid; read/write pointers and COUNT = 0;
  - FLAGS = 4'b0000;
  - OUT_VALID = 0, FWD_VALID = 0;
  - OUT_DATA, OUT_DEST, OUT_WB_EN, FWD_DEST, FWD_DATA = 0.
- Reset mid-operation discards all entries immediately.
- Push: IN_VALID & IN_READY at a rising edge. Pop: OUT_VALID & OUT_READY at a rising edge.
- IN_READY = (COUNT < DEPTH), derived from registered state only; no combinational path from OUT_READY. Full with OUT_READY=1 still gives IN_READY=0.
- OUT_VALID = (COUNT != 0). OUT_* driven from the head entry, registered storage, stable while OUT_VALID & !OUT_READY.
- Latency: a push into an empty buffer yields OUT_VALID=1 with that data the next cycle.
- Simultaneous push and pop (COUNT between 1 and DEPTH-1): COUNT unchanged, order preserved.
- Pointers wrap modulo DEPTH.
- Flag update happens on push only, and only when IN_FLAG_WE=1, per S_ALU class:
  - 0000 ADD, 0001 SUB: FLAGS <= FLAG_OUT (all four bits).
  - 0010 AND, 0011 OR, 0100 XOR, 1100 IDT: S,Z <= FLAG_OUT[3:2]; C,V held.
  - 1000 SLL, 1001 SLR, 1010 SRL, 1011 SRA: S,Z,C <= FLAG_OUT[3:1]; V held.
  - 1111 NON and all other codes: no update.
- FLAGS changes the cycle after the push, independent of when writeback pops.
- FWD_VALID/FWD_DEST/FWD_DATA reflect the most recently pushed still-buffered entry.
  - FWD_VALID = 0 when empty or when that entry has WB_EN = 0.
  - When the last remaining entry pops without a push, FWD_VALID falls next cycle.
- FLUSH=1:
  - next cycle COUNT = 0, OUT_VALID = 0, FWD_VALID = 0;
  - a simultaneous push is dropped and its flag update is suppressed;
  - a simultaneous pop is discarded;
  - FLAGS keeps its current value.
- No overflow or underflow is possible through the handshake. IN_VALID while full is simply not accepted, and upstream must hold its data.

Test Plan:
- Reset then push ADD result 0x8000, FLAG_OUT=4'b1011, IN_FLAG_WE=1, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_DATA=0x8000, FLAGS=4'b1011; COUNT returns to 0 after pop.
- FLAGS=4'b0011, push AND with FLAG_OUT=4'b0100 -> FLAGS=4'b0111. Then push SRL with FLAG_OUT=4'b0010 -> FLAGS=4'b0011. Then push NON -> FLAGS unchanged.
- OUT_READY=0, push 0x0001 then 0x0002 -> COUNT=2, IN_READY=0, third push stalls. Raise OUT_READY -> pops 0x0001 then 0x0002 in order; IN_READY rises the cycle after the first pop.
- COUNT=1 with simultaneous push 0x00AA and pop -> COUNT stays 1, OUT_DATA=0x00AA next cycle. FWD_DEST follows the newest entry; FWD_VALID=0 for IN_WB_EN=0.
- COUNT=2, FLUSH=1 with concurrent SUB push (IN_FLAG_WE=1) -> COUNT=0, OUT_VALID=0, FLAGS unchanged.
- N_RST low asynchronously between edges with COUNT=2, FLAGS=4'b1111 -> outputs clear immediately, FLAGS=0, IN_READY=1 after release.

Source files
------------

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: execute-to-writeback result FIFO with flag register
// and a forwarding view of the newest buffered entry.
module alu_result_buffer #(
   parameter int DATA_W = 16,
   parameter int DEST_W = 3,
   parameter int DEPTH  = 2
) (
   input  logic                     CLK,
   input  logic                     N_RST,
   input  logic                     FLUSH,
   input  logic                     IN_VALID,
   output logic                     IN_READY,
   input  logic [DATA_W-1:0]        ALU_OUT,
   input  logic [3:0]               FLAG_OUT,
   input  logic [3:0]               S_ALU,
   input  logic [DEST_W-1:0]        IN_DEST,
   input  logic                     IN_WB_EN,
   input  logic                     IN_FLAG_WE,
   output logic                     OUT_VALID,
   input  logic                     OUT_READY,
   output logic [DATA_W-1:0]        OUT_DATA,
   output logic [DEST_W-1:0]        OUT_DEST,
   output logic                     OUT_WB_EN,
   output logic [3:0]               FLAGS,
   output logic                     FWD_VALID,
   output logic [DEST_W-1:0]        FWD_DEST,
   output logic [DATA_W-1:0]        FWD_DATA,
   output logic [$clog2(DEPTH):0]   COUNT
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DEST_W-1:0] dest_q [DEPTH];
   logic [DEPTH-1:0]  wb_q;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  new_ptr;
   logic [CNT_W-1:0]  cnt;
   logic [3:0]        flags_q;
   logic [3:0]        flags_d;
   logic              push;
   logic              pop;

   assign IN_READY  = cnt < CNT_W'(DEPTH);
   assign OUT_VALID = cnt != '0;

   // a flush swallows any handshake that coincides with it
   assign push = IN_VALID & IN_READY & ~FLUSH;
   assign pop  = OUT_VALID & OUT_READY & ~FLUSH;

   assign new_ptr = wr_ptr - PTR_W'(1);

   assign OUT_DATA  = data_q[rd_ptr];
   assign OUT_DEST  = dest_q[rd_ptr];
   assign OUT_WB_EN = wb_q[rd_ptr];

   assign FWD_VALID = OUT_VALID & wb_q[new_ptr];
   assign FWD_DEST  = dest_q[new_ptr];
   assign FWD_DATA  = data_q[new_ptr];

   assign FLAGS = flags_q;
   assign COUNT = cnt;

   // entry storage, written at the tail on push
   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            dest_q[i] <= '0;
         end
         wb_q <= '0;
      end else if (push) begin
         data_q[wr_ptr] <= ALU_OUT;
         dest_q[wr_ptr] <= IN_DEST;
         wb_q[wr_ptr]   <= IN_WB_EN;
      end
   end

   // pointers and occupancy; pointers wrap naturally at DEPTH
   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (FLUSH) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // flag merge by opcode class, only for accepted flag-writing results
   always_comb begin
      flags_d = flags_q;
      if (push && IN_FLAG_WE) begin
         case (S_ALU)
            4'b0000, 4'b0001:
               flags_d = FLAG_OUT;
            4'b0010, 4'b0011, 4'b0100, 4'b1100:
               flags_d = {FLAG_OUT[3:2], flags_q[1:0]};
            4'b1000, 4'b1001, 4'b1010, 4'b1011:
               flags_d = {FLAG_OUT[3:1], flags_q[0]};
            default:
               flags_d = flags_q;
         endcase
      end
   end

   // architectural flag register
   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) flags_q <= 4'b0000;
      else        flags_q <= flags_d;
   end

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: scoreboard bench for alu_result_buffer.
// Inputs change 1 time unit after rising edges; monitor samples on falling edges.
module tb_alu_result_buffer;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_SRL = 4'b1010;
   localparam logic [3:0] OP_NON = 4'b1111;

   logic        CLK = 0;
   logic        N_RST = 0;
   logic        FLUSH = 0;
   logic        IN_VALID = 0;
   logic        IN_READY;
   logic [15:0] ALU_OUT = 0;
   logic [3:0]  FLAG_OUT = 0;
   logic [3:0]  S_ALU = 0;
   logic [2:0]  IN_DEST = 0;
   logic        IN_WB_EN = 0;
   logic        IN_FLAG_WE = 0;
   logic        OUT_VALID;
   logic        OUT_READY = 0;
   logic [15:0] OUT_DATA;
   logic [2:0]  OUT_DEST;
   logic        OUT_WB_EN;
   logic [3:0]  FLAGS;
   logic        FWD_VALID;
   logic [2:0]  FWD_DEST;
   logic [15:0] FWD_DATA;
   logic [1:0]  COUNT;

   int n_vec = 0;
   int n_err = 0;

   logic [19:0] sb_q[$];
   logic [19:0] last_e = '0;
   logic [3:0]  exp_flags = '0;

   always #5 CLK = ~CLK;

   alu_result_buffer dut (
      .CLK(CLK), .N_RST(N_RST), .FLUSH(FLUSH),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .ALU_OUT(ALU_OUT), .FLAG_OUT(FLAG_OUT), .S_ALU(S_ALU),
      .IN_DEST(IN_DEST), .IN_WB_EN(IN_WB_EN), .IN_FLAG_WE(IN_FLAG_WE),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .OUT_DATA(OUT_DATA), .OUT_DEST(OUT_DEST), .OUT_WB_EN(OUT_WB_EN),
      .FLAGS(FLAGS), .FWD_VALID(FWD_VALID), .FWD_DEST(FWD_DEST),
      .FWD_DATA(FWD_DATA), .COUNT(COUNT)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] flag_model(input logic [3:0] old,
                                             input logic [3:0] op,
                                             input logic [3:0] f);
      logic [3:0] r;
      r = old;
      if (op == OP_ADD || op == OP_SUB) r = f;
      else if (op inside {4'b0010, 4'b0011, 4'b0100, 4'b1100})
         r = {f[3], f[2], old[1], old[0]};
      else if (op inside {4'b1000, 4'b1001, 4'b1010, 4'b1011})
         r = {f[3], f[2], f[1], old[0]};
      return r;
   endfunction

   // monitor + scoreboard
   always @(negedge CLK) begin
      logic [19:0] e;
      logic        fv;
      if (!N_RST) begin
         sb_q.delete();
         last_e = '0;
         exp_flags = '0;
      end
      fv = (sb_q.size() != 0) && last_e[19];
      chk("flags", FLAGS, exp_flags);
      chk("count", COUNT, sb_q.size());
      chk("out_valid", OUT_VALID, sb_q.size() != 0);
      chk("in_ready", IN_READY, sb_q.size() < 2);
      chk("fwd_valid", FWD_VALID, fv);
      if (fv) begin
         chk("fwd_dest", FWD_DEST, last_e[18:16]);
         chk("fwd_data", FWD_DATA, last_e[15:0]);
      end
      if (N_RST) begin
         if (FLUSH) begin
            sb_q.delete();
         end else begin
            if (OUT_VALID && OUT_READY) begin
               if (sb_q.size() == 0) begin
                  chk("pop_empty", OUT_VALID, 0);
               end else begin
                  e = sb_q.pop_front();
                  chk("out_data", OUT_DATA, e[15:0]);
                  chk("out_dest", OUT_DEST, e[18:16]);
                  chk("out_wb_en", OUT_WB_EN, e[19]);
               end
            end
            if (IN_VALID && IN_READY) begin
               e = {IN_WB_EN, IN_DEST, ALU_OUT};
               sb_q.push_back(e);
               last_e = e;
               if (IN_FLAG_WE)
                  exp_flags = flag_model(exp_flags, S_ALU, FLAG_OUT);
            end
         end
      end
   end

   task automatic set_in(input logic [15:0] d, input logic [3:0] f,
                         input logic [3:0] op, input logic [2:0] dst,
                         input logic wb, input logic fwe);
      IN_VALID   = 1;
      ALU_OUT    = d;
      FLAG_OUT   = f;
      S_ALU      = op;
      IN_DEST    = dst;
      IN_WB_EN   = wb;
      IN_FLAG_WE = fwe;
   endtask

   task automatic push(input logic [15:0] d, input logic [3:0] f,
                       input logic [3:0] op, input logic [2:0] dst,
                       input logic wb, input logic fwe);
      int n;
      set_in(d, f, op, dst, wb, fwe);
      n = 0;
      while (!IN_READY && n < 20) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("push_ready", IN_READY, 1);
      @(posedge CLK); #1;
      IN_VALID   = 0;
      IN_FLAG_WE = 0;
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_out_data", OUT_DATA, 0);
      chk("rst_fwd_data", FWD_DATA, 0);
      chk("rst_out_dest", OUT_DEST, 0);
      N_RST = 1;
      @(posedge CLK); #1;

      // single ADD result, immediate pop
      OUT_READY = 1;
      push(16'h8000, 4'b1011, OP_ADD, 3'd1, 1, 1);
      chk("t1_valid", OUT_VALID, 1);
      chk("t1_data", OUT_DATA, 16'h8000);
      chk("t1_flags", FLAGS, 4'b1011);
      chk("t1_fwd", FWD_VALID, 1);
      @(posedge CLK); #1;
      chk("t1_count", COUNT, 0);
      chk("t1_fwd_fall", FWD_VALID, 0);

      // flag classes
      push(16'h0003, 4'b0011, OP_ADD, 3'd2, 1, 1);
      chk("t2_add", FLAGS, 4'b0011);
      push(16'h0004, 4'b0100, OP_AND, 3'd2, 1, 1);
      chk("t2_and", FLAGS, 4'b0111);
      push(16'h0005, 4'b0010, OP_SRL, 3'd2, 1, 1);
      chk("t2_srl", FLAGS, 4'b0011);
      push(16'h0006, 4'b1101, OP_NON, 3'd2, 1, 1);
      chk("t2_non", FLAGS, 4'b0011);
      @(posedge CLK); #1;

      // backpressure and ordering
      OUT_READY = 0;
      push(16'h0001, 4'b1111, OP_ADD, 3'd1, 1, 0);
      push(16'h0002, 4'b1111, OP_ADD, 3'd2, 1, 0);
      chk("t3_full", COUNT, 2);
      chk("t3_nrdy", IN_READY, 0);
      set_in(16'h0003, 4'b1111, OP_ADD, 3'd3, 1, 0);
      repeat (2) @(posedge CLK);
      #1;
      chk("t3_stall", COUNT, 2);
      chk("t3_head", OUT_DATA, 16'h0001);
      OUT_READY = 1;
      @(posedge CLK); #1;
      chk("t3_rdy_rise", IN_READY, 1);
      chk("t3_cnt1", COUNT, 1);
      chk("t3_second", OUT_DATA, 16'h0002);
      @(posedge CLK); #1;
      IN_VALID = 0;
      chk("t3_pp_cnt", COUNT, 1);
      chk("t3_third", OUT_DATA, 16'h0003);
      @(posedge CLK); #1;
      chk("t3_empty", COUNT, 0);

      // simultaneous push/pop and forwarding
      OUT_READY = 0;
      push(16'h0055, 4'b0000, OP_ADD, 3'd4, 1, 0);
      chk("t4_fwd_v", FWD_VALID, 1);
      chk("t4_fwd_d", FWD_DEST, 3'd4);
      chk("t4_fwd_x", FWD_DATA, 16'h0055);
      set_in(16'h00AA, 4'b0000, OP_ADD, 3'd5, 0, 0);
      OUT_READY = 1;
      @(posedge CLK); #1;
      IN_VALID = 0;
      chk("t4_cnt", COUNT, 1);
      chk("t4_data", OUT_DATA, 16'h00AA);
      chk("t4_fwd_dest", FWD_DEST, 3'd5);
      chk("t4_fwd_nowb", FWD_VALID, 0);
      @(posedge CLK); #1;
      chk("t4_empty", COUNT, 0);

      // flush with one entry and a concurrent flag-writing push
      OUT_READY = 0;
      push(16'h0011, 4'b0000, OP_ADD, 3'd1, 1, 0);
      set_in(16'h0022, 4'b1010, OP_SUB, 3'd2, 1, 1);
      FLUSH = 1;
      OUT_READY = 1;
      @(posedge CLK); #1;
      FLUSH = 0;
      IN_VALID = 0;
      IN_FLAG_WE = 0;
      chk("t5a_cnt", COUNT, 0);
      chk("t5a_flags", FLAGS, 4'b0011);

      // flush while full
      OUT_READY = 0;
      push(16'h0033, 4'b0000, OP_ADD, 3'd3, 1, 0);
      push(16'h0044, 4'b0000, OP_ADD, 3'd4, 1, 0);
      chk("t5b_full", COUNT, 2);
      set_in(16'h0055, 4'b1100, OP_SUB, 3'd5, 1, 1);
      FLUSH = 1;
      OUT_READY = 1;
      @(posedge CLK); #1;
      FLUSH = 0;
      IN_VALID = 0;
      IN_FLAG_WE = 0;
      chk("t5b_cnt", COUNT, 0);
      chk("t5b_valid", OUT_VALID, 0);
      chk("t5b_fwd", FWD_VALID, 0);
      chk("t5b_flags", FLAGS, 4'b0011);

      // asynchronous reset mid-operation
      OUT_READY = 0;
      push(16'h0077, 4'b1111, OP_ADD, 3'd6, 1, 1);
      push(16'h0088, 4'b0000, OP_ADD, 3'd7, 1, 0);
      chk("t6_full", COUNT, 2);
      chk("t6_flags", FLAGS, 4'b1111);
      #2;
      N_RST = 0;
      #1;
      chk("t6_cnt", COUNT, 0);
      chk("t6_valid", OUT_VALID, 0);
      chk("t6_flags0", FLAGS, 4'b0000);
      chk("t6_data", OUT_DATA, 0);
      chk("t6_fwd", FWD_VALID, 0);
      @(posedge CLK); #3;
      N_RST = 1;
      @(posedge CLK); #1;
      chk("t6_rdy", IN_READY, 1);
      chk("t6_cnt_after", COUNT, 0);
      @(posedge CLK); #1;
      chk("sb_drained", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
